// File: rtl/udt_pkt_classifier.sv
// UDT receive-side packet classifier: decodes the header type, tags every beat of the
// packet one-hot, drops unknown types, truncates over-length packets, keeps per-type stats.
module udt_pkt_classifier #(
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 core_rst,
    input  logic [DATA_W-1:0]    in_tdata,
    input  logic                 in_tvalid,
    output logic                 in_tready,
    input  logic                 in_tlast,
    output logic [DATA_W-1:0]    out_tdata,
    output logic                 out_tvalid,
    input  logic                 out_tready,
    output logic                 out_tlast,
    output logic [6:0]           out_type,
    output logic                 err_unknown,
    output logic                 err_overlen,
    input  logic                 cnt_clr,
    output logic [7*CNT_W-1:0]   type_cnt,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        S_HDR,
        S_PASS,
        S_DROP
    } state_t;

    state_t            state, state_nxt;
    logic [BW-1:0]     beat_cnt, beat_cnt_nxt;
    logic [6:0]        cur_type;
    logic [6:0]        hdr_type;
    logic [6:0]        push_type;
    logic [15:0]       type_field;
    logic              accept;
    logic              push;
    logic              push_last;
    logic              pop;
    logic              hit_unknown;
    logic              hit_overlen;

    logic [1:0]        fill;
    logic [DATA_W-1:0] skid_data;
    logic              skid_last;
    logic [6:0]        skid_type;

    logic [CNT_W-1:0]  tcnt [7];

    assign in_tready = (fill != 2'd2) || (state == S_DROP);
    assign accept    = in_tvalid & in_tready;
    assign pop       = out_tvalid & out_tready;
    assign push_type = (state == S_HDR) ? hdr_type : cur_type;

    always_comb begin
        type_field = in_tdata[DATA_W-1 -: 16];
        hdr_type   = '0;
        if (!type_field[15]) begin
            hdr_type = 7'h01;
        end else begin
            case (type_field[14:0])
                15'd0:   hdr_type = 7'h02;
                15'd1:   hdr_type = 7'h04;
                15'd2:   hdr_type = 7'h08;
                15'd3:   hdr_type = 7'h10;
                15'd5:   hdr_type = 7'h20;
                15'd6:   hdr_type = 7'h40;
                default: hdr_type = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (core_rst) begin
            state    <= S_HDR;
            beat_cnt <= '0;
            cur_type <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            if (state == S_HDR && push) begin
                cur_type <= hdr_type;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        push         = 1'b0;
        push_last    = in_tlast;
        hit_unknown  = 1'b0;
        hit_overlen  = 1'b0;
        case (state)
            S_HDR: begin
                if (accept) begin
                    if (hdr_type != '0) begin
                        push         = 1'b1;
                        beat_cnt_nxt = BW'(1);
                        state_nxt    = in_tlast ? S_HDR : S_PASS;
                    end else begin
                        hit_unknown = 1'b1;
                        state_nxt   = in_tlast ? S_HDR : S_DROP;
                    end
                end
            end
            S_PASS: begin
                if (accept) begin
                    push         = 1'b1;
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    if (in_tlast) begin
                        state_nxt = S_HDR;
                    end else if (beat_cnt_nxt == BW'(MAX_BEATS)) begin
                        // the beat that hits the limit is the truncated packet's last beat
                        push_last   = 1'b1;
                        hit_overlen = 1'b1;
                        state_nxt   = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (accept && in_tlast) begin
                    state_nxt = S_HDR;
                end
            end
            default: state_nxt = S_HDR;
        endcase
    end

    // Two-entry output stage: the out_* registers are the head, skid_* holds the overflow beat.
    always_ff @(posedge clk) begin
        if (core_rst) begin
            fill       <= 2'd0;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tlast  <= 1'b0;
            out_type   <= '0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            skid_type  <= '0;
        end else begin
            case (fill)
                2'd0: begin
                    if (push) begin
                        out_tdata  <= in_tdata;
                        out_tlast  <= push_last;
                        out_type   <= push_type;
                        out_tvalid <= 1'b1;
                        fill       <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        out_tdata <= in_tdata;
                        out_tlast <= push_last;
                        out_type  <= push_type;
                    end else if (push) begin
                        skid_data <= in_tdata;
                        skid_last <= push_last;
                        skid_type <= push_type;
                        fill      <= 2'd2;
                    end else if (pop) begin
                        out_tvalid <= 1'b0;
                        fill       <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        out_tdata <= skid_data;
                        out_tlast <= skid_last;
                        out_type  <= skid_type;
                        fill      <= 2'd1;
                    end
                end
                default: begin
                    out_tvalid <= 1'b0;
                    fill       <= 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (core_rst) begin
            err_unknown <= 1'b0;
            err_overlen <= 1'b0;
        end else begin
            err_unknown <= hit_unknown;
            err_overlen <= hit_overlen;
        end
    end

    always_ff @(posedge clk) begin
        if (core_rst || cnt_clr) begin
            for (int unsigned i = 0; i < 7; i++) begin
                tcnt[i] <= '0;
            end
            drop_cnt <= '0;
        end else begin
            if (state == S_HDR && push) begin
                for (int unsigned i = 0; i < 7; i++) begin
                    if (hdr_type[i] && tcnt[i] != '1) begin
                        tcnt[i] <= tcnt[i] + 1'b1;
                    end
                end
            end
            if ((hit_unknown || hit_overlen) && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        type_cnt = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            type_cnt[i*CNT_W +: CNT_W] = tcnt[i];
        end
    end

endmodule

// File: tb/tb_udt_pkt_classifier.sv
// Directed bench for udt_pkt_classifier: table of packets with hand-computed tags/lengths
// plus hand-written sequences for latency, counter clear/saturation and mid-packet reset.
module tb_udt_pkt_classifier;

    localparam int DW   = 64;
    localparam int MB   = 256;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              core_rst;
    logic [DW-1:0]     in_tdata;
    logic              in_tvalid;
    logic              in_tready;
    logic              in_tlast;
    logic [DW-1:0]     out_tdata;
    logic              out_tvalid;
    logic              out_tready = 1'b1;
    logic              out_tlast;
    logic [6:0]        out_type;
    logic              err_unknown;
    logic              err_overlen;
    logic              cnt_clr;
    logic [7*CW-1:0]   type_cnt;
    logic [CW-1:0]     drop_cnt;

    always #5 clk = ~clk;

    udt_pkt_classifier #(.DATA_W(DW), .MAX_BEATS(MB), .CNT_W(CW)) dut (
        .clk         (clk),
        .core_rst    (core_rst),
        .in_tdata    (in_tdata),
        .in_tvalid   (in_tvalid),
        .in_tready   (in_tready),
        .in_tlast    (in_tlast),
        .out_tdata   (out_tdata),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .out_tlast   (out_tlast),
        .out_type    (out_type),
        .err_unknown (err_unknown),
        .err_overlen (err_overlen),
        .cnt_clr     (cnt_clr),
        .type_cnt    (type_cnt),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [6:0]    ty;
    } beat_t;

    typedef struct {
        logic [15:0] t;
        int          n;
        logic [6:0]  etype;
        int          ebeats;
        int          unk;
        int          ovl;
        bit          rnd;
        bit          drain;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    beat_t got_q[$];
    beat_t exp_q[$];
    int    n_unk = 0, n_ovl = 0, exp_unk = 0, exp_ovl = 0;
    int    exp_cnt[7];
    int    exp_drop = 0;
    int    rdy_mode = 0;
    vec_t  vecs[13];

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_tready = 1'b1;
            1:       out_tready = 1'($urandom_range(0, 1));
            default: out_tready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!core_rst) begin
            if (out_tvalid && out_tready) begin
                beat_t bt;
                bt.d  = out_tdata;
                bt.l  = out_tlast;
                bt.ty = out_type;
                got_q.push_back(bt);
            end
            if (err_unknown) n_unk++;
            if (err_overlen) n_ovl++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input logic [15:0] t, input int id, input int b);
        return {t, 16'(id), 32'(b)};
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drives n_send beats of an n-beat packet; returns number of cycles stalled by in_tready.
    task automatic send_pkt(input logic [15:0] t, input int n, input int id, input int n_send,
                            output int stalls);
        stalls = 0;
        for (int b = 0; b < n_send; b++) begin
            bit ok;
            int g;
            in_tdata  = data_of(t, id, b);
            in_tlast  = (b == n - 1);
            in_tvalid = 1'b1;
            ok = 1'b0;
            g  = 0;
            while (!ok) begin
                @(negedge clk);
                ok = in_tready;
                @(posedge clk);
                if (!ok) stalls++;
                g++;
                if (!ok && g > 1000) begin
                    checks++;
                    errors++;
                    $display("FAIL handshake_timeout: in_tready 0 for %0d cycles, required 1", g);
                    break;
                end
            end
            #1;
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic expect_pkt(input logic [15:0] t, input int n, input int id, input logic [6:0] ety,
                              input int eb, input int unk, input int ovl, input bit counted);
        for (int b = 0; b < eb; b++) begin
            beat_t bt;
            bt.d  = data_of(t, id, b);
            bt.l  = (b == n - 1) || (b == MB - 1);
            bt.ty = ety;
            exp_q.push_back(bt);
        end
        exp_unk += unk;
        exp_ovl += ovl;
        if (counted) begin
            for (int k = 0; k < 7; k++) begin
                if (ety[k]) exp_cnt[k] = sat_inc(exp_cnt[k]);
            end
            for (int j = 0; j < unk + ovl; j++) exp_drop = sat_inc(exp_drop);
        end
    endtask

    task automatic drain();
        int idle = 0;
        int g = 0;
        while (idle < 4 && g < 2000) begin
            @(negedge clk);
            if (out_tvalid) idle = 0;
            else idle++;
            g++;
        end
        if (g >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: out_tvalid still 1 after %0d cycles, required 0", g);
        end
    endtask

    task automatic check_all(input string tag);
        int m;
        chk($sformatf("%s nbeats", tag), 64'(got_q.size()), 64'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s beat%0d data", tag, i), got_q[i].d, exp_q[i].d);
            chk($sformatf("%s beat%0d last", tag, i), 64'(got_q[i].l), 64'(exp_q[i].l));
            chk($sformatf("%s beat%0d type", tag, i), 64'(got_q[i].ty), 64'(exp_q[i].ty));
        end
        chk($sformatf("%s err_unknown_pulses", tag), 64'(n_unk), 64'(exp_unk));
        chk($sformatf("%s err_overlen_pulses", tag), 64'(n_ovl), 64'(exp_ovl));
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("%s type_cnt%0d", tag, k), 64'(type_cnt[k*CW +: CW]), 64'(exp_cnt[k]));
        end
        chk($sformatf("%s drop_cnt", tag), 64'(drop_cnt), 64'(exp_drop));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk($sformatf("%s out_tvalid", tag), 64'(out_tvalid), 64'd0);
        chk($sformatf("%s out_tlast", tag), 64'(out_tlast), 64'd0);
        chk($sformatf("%s out_type", tag), 64'(out_type), 64'd0);
        chk($sformatf("%s out_tdata", tag), out_tdata, 64'd0);
        chk($sformatf("%s err_unknown", tag), 64'(err_unknown), 64'd0);
        chk($sformatf("%s err_overlen", tag), 64'(err_overlen), 64'd0);
        chk($sformatf("%s in_tready", tag), 64'(in_tready), 64'd1);
        chk($sformatf("%s type_cnt", tag), 64'(type_cnt), 64'd0);
        chk($sformatf("%s drop_cnt", tag), 64'(drop_cnt), 64'd0);
    endtask

    initial begin
        int  st;
        bit  need_sync;

        //        type      n    etype ebeats unk ovl rnd drain
        vecs[0]  = '{16'h0000,   4, 7'h01,   4, 0, 0, 1'b0, 1'b1};
        vecs[1]  = '{16'h8002,   1, 7'h08,   1, 0, 0, 1'b0, 1'b1};
        vecs[2]  = '{16'h8004,   3, 7'h00,   0, 1, 0, 1'b0, 1'b1};
        vecs[3]  = '{16'h1234, 300, 7'h01, 256, 0, 1, 1'b0, 1'b1};
        vecs[4]  = '{16'h7FFF, 256, 7'h01, 256, 0, 0, 1'b0, 1'b1};
        vecs[5]  = '{16'h8000,   3, 7'h02,   3, 0, 0, 1'b1, 1'b0};
        vecs[6]  = '{16'h8001,   1, 7'h04,   1, 0, 0, 1'b1, 1'b0};
        vecs[7]  = '{16'h8002,   2, 7'h08,   2, 0, 0, 1'b1, 1'b0};
        vecs[8]  = '{16'h8003,   5, 7'h10,   5, 0, 0, 1'b1, 1'b0};
        vecs[9]  = '{16'h8005,   2, 7'h20,   2, 0, 0, 1'b1, 1'b0};
        vecs[10] = '{16'h8006,   4, 7'h40,   4, 0, 0, 1'b1, 1'b1};
        vecs[11] = '{16'h8007,   1, 7'h00,   0, 1, 0, 1'b0, 1'b0};
        vecs[12] = '{16'hFFFF,   2, 7'h00,   0, 1, 0, 1'b0, 1'b1};

        for (int k = 0; k < 7; k++) exp_cnt[k] = 0;
        core_rst  = 1'b1;
        in_tvalid = 1'b0;
        in_tdata  = '0;
        in_tlast  = 1'b0;
        cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1 core_rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // accepted beat must be on the output one cycle later
        sync();
        in_tdata  = data_of(16'h0000, 16'hABCD, 0);
        in_tlast  = 1'b1;
        in_tvalid = 1'b1;
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        @(negedge clk);
        chk("lat out_tvalid", 64'(out_tvalid), 64'd1);
        chk("lat out_tdata", out_tdata, data_of(16'h0000, 16'hABCD, 0));
        chk("lat out_type", 64'(out_type), 64'h01);
        chk("lat out_tlast", 64'(out_tlast), 64'd1);
        expect_pkt(16'h0000, 1, 16'hABCD, 7'h01, 1, 0, 0, 1'b1);
        drain();
        check_all("lat");

        need_sync = 1'b1;
        for (int v = 0; v < 13; v++) begin
            rdy_mode = vecs[v].rnd ? 1 : 0;
            if (need_sync) sync();
            send_pkt(vecs[v].t, vecs[v].n, v, vecs[v].n, st);
            expect_pkt(vecs[v].t, vecs[v].n, v, vecs[v].etype, vecs[v].ebeats,
                       vecs[v].unk, vecs[v].ovl, 1'b1);
            if (vecs[v].unk != 0) chk($sformatf("v%0d drop_stalls", v), 64'(st), 64'd0);
            need_sync = vecs[v].drain;
            if (vecs[v].drain) begin
                drain();
                check_all($sformatf("v%0d", v));
            end
        end
        rdy_mode = 0;

        // DATA counter saturates at all-ones
        sync();
        for (int i = 0; i < 14; i++) begin
            send_pkt(16'h0100, 1, 100 + i, 1, st);
            expect_pkt(16'h0100, 1, 100 + i, 7'h01, 1, 0, 0, 1'b1);
        end
        drain();
        check_all("sat");

        // clear wins over a same-cycle increment
        sync();
        cnt_clr = 1'b1;
        send_pkt(16'h0002, 1, 200, 1, st);
        cnt_clr = 1'b0;
        for (int k = 0; k < 7; k++) exp_cnt[k] = 0;
        exp_drop = 0;
        expect_pkt(16'h0002, 1, 200, 7'h01, 1, 0, 0, 1'b0);
        drain();
        check_all("clr");
        sync();
        send_pkt(16'h0003, 2, 201, 2, st);
        expect_pkt(16'h0003, 2, 201, 7'h01, 2, 0, 0, 1'b1);
        drain();
        check_all("clr2");

        // reset in the middle of a forwarded packet, then a NAK packet
        sync();
        send_pkt(16'h0000, 10, 300, 3, st);
        core_rst = 1'b1;
        @(posedge clk);
        #1 core_rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        got_q.delete();
        exp_q.delete();
        n_unk = 0;
        n_ovl = 0;
        exp_unk = 0;
        exp_ovl = 0;
        exp_drop = 0;
        for (int k = 0; k < 7; k++) exp_cnt[k] = 0;
        sync();
        send_pkt(16'h8003, 2, 301, 2, st);
        expect_pkt(16'h8003, 2, 301, 7'h10, 2, 0, 0, 1'b1);
        drain();
        check_all("rst_nak");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
